// File: rtl/event_cdc_pkg.sv
// Shared definitions for the toggle-based event CDC link (tx and rx ends).
package event_cdc_pkg;

  // FSM encodings shared by strobe_to_toggle_tx and toggle_to_strobe.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } cdc_state_t;

  // Smallest legal flip spacing and synchronizer depth.
  localparam int MIN_GAP_MIN     = 2;
  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop level synchronizer; output is the last stage of the chain.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/strobe_to_toggle_tx.sv
// Source end of the toggle event CDC link: queues strobes in a saturating
// counter and emits one o_toggle flip per event, spaced for safe recovery.
// Build option: STROBE_TO_TOGGLE_TX_ACK_EN selects closed-loop pacing on the
// synchronized echo i_ack_toggle; otherwise flips are paced by a MIN_GAP timer.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no flip in flight; next strobe or queued event flips at once
// ST_WAIT | flip in flight; hold off until gap expires / ack matches
//
// A WAIT whose gap has just completed behaves like IDLE for one decision:
// if work is waiting it flips and reloads directly, so a drain runs at exactly
// one flip per MIN_GAP cycles instead of losing a cycle passing through IDLE.
module strobe_to_toggle_tx
  import event_cdc_pkg::*;
#(
  parameter int CNT_WIDTH   = 4,
  parameter int MIN_GAP     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_strobe,
  input  logic                 i_ack_toggle,
  output logic                 o_toggle,
  output logic [CNT_WIDTH-1:0] o_pending,
  output logic                 o_busy,
  output logic                 o_drop,
  output logic                 o_overflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  if (MIN_GAP < MIN_GAP_MIN) begin : g_bad_min_gap
    $error("strobe_to_toggle_tx: MIN_GAP must be at least 2");
  end
  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync_stages
    $error("strobe_to_toggle_tx: SYNC_STAGES must be at least 2");
  end

  cdc_state_t            r_state;
  cdc_state_t            w_state_nxt;
  logic                  r_toggle;
  logic [CNT_WIDTH-1:0]  r_pending;
  logic [CNT_WIDTH-1:0]  w_pending_nxt;
  logic                  r_drop;
  logic                  r_overflow;
  logic                  w_gap_done;
  logic                  w_work;
  logic                  w_flip;
  logic                  w_bypass;
  logic                  w_inc;
  logic                  w_dec;
  logic                  w_sat;

`ifdef STROBE_TO_TOGGLE_TX_ACK_EN
  logic w_ack_sync;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_ack_toggle),
    .o_q   (w_ack_sync)
  );

  // The destination has caught up once its echo equals our current level.
  assign w_gap_done = (w_ack_sync == r_toggle);
`else
  localparam int               GAP_W    = $clog2(MIN_GAP);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);

  logic [GAP_W-1:0] r_gap;
  logic             w_unused_ack;

  assign w_unused_ack = i_ack_toggle;

  // Gap down-counter: reload on every flip, count down to zero while waiting.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                   r_gap <= '0;
    else if (w_flip)                             r_gap <= GAP_LOAD;
    else if (r_state == ST_WAIT && r_gap != '0)  r_gap <= r_gap - 1'b1;
  end

  assign w_gap_done = (r_gap == '0);
`endif

  assign w_work = i_strobe | (r_pending != '0);

  // Next-state and flip decision.
  always_comb begin
    w_state_nxt = r_state;
    w_flip      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_work) begin
          w_flip      = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_gap_done) begin
          if (w_work) w_flip = 1'b1;
          else        w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A strobe arriving with an empty queue rides the flip directly and is never counted.
  assign w_bypass = w_flip & i_strobe & (r_pending == '0);
  assign w_dec    = w_flip & (r_pending != '0);
  assign w_inc    = i_strobe & ~w_bypass;
  assign w_sat    = w_inc & ~w_dec & (r_pending == CNT_MAX);

  // Saturating pending-count update.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_inc && !w_dec && !w_sat) w_pending_nxt = r_pending + 1'b1;
    else if (w_dec && !w_inc)      w_pending_nxt = r_pending - 1'b1;
  end

  // Registered state, toggle level, queue and error flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_toggle   <= 1'b0;
      r_pending  <= '0;
      r_drop     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_drop     <= w_sat;
      if (w_flip) r_toggle   <= ~r_toggle;
      if (w_sat)  r_overflow <= 1'b1;
    end
  end

  assign o_toggle   = r_toggle;
  assign o_pending  = r_pending;
  assign o_busy     = (r_state != ST_IDLE) | (r_pending != '0);
  assign o_drop     = r_drop;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_strobe_to_toggle_tx.sv
// Bench for strobe_to_toggle_tx (CNT_WIDTH=2, MIN_GAP=4, SYNC_STAGES=2).
// Expected flip cycles are queued by the stimulus; a monitor pops one per
// observed o_toggle change. Define STROBE_TO_TOGGLE_TX_ACK_EN for ack mode.
module tb_strobe_to_toggle_tx;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_strobe;
  logic       i_ack_toggle;
  logic       o_toggle;
  logic [1:0] o_pending;
  logic       o_busy;
  logic       o_drop;
  logic       o_overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[$];

  logic       prev_tgl = 1'b0;
  logic [2:0] r_dly    = 3'b000;
  logic       hold_ack = 1'b0;

  strobe_to_toggle_tx #(
    .CNT_WIDTH   (2),
    .MIN_GAP     (4),
    .SYNC_STAGES (2)
  ) u_dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_strobe     (i_strobe),
    .i_ack_toggle (i_ack_toggle),
    .o_toggle     (o_toggle),
    .o_pending    (o_pending),
    .o_busy       (o_busy),
    .o_drop       (o_drop),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Echo path: o_toggle delayed three half-cycle-aligned stages, freezable.
  always @(negedge clk) if (!hold_ack) r_dly <= {r_dly[1:0], o_toggle};
  assign i_ack_toggle = r_dly[2];

  // Flip monitor / scoreboard.
  always @(negedge clk) begin
    if (i_rst) prev_tgl = o_toggle;
    else if (o_toggle !== prev_tgl) begin
      prev_tgl = o_toggle;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL flip_unexpected: flip at cycle %0d, none expected", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL flip_cycle: flip at cycle %0d, expected cycle %0d", cyc, e);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!o_busy) done = 1'b1;
    end
    chk("wait_idle_timeout", int'(done), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    i_rst    = 1'b1;
    i_strobe = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_toggle",   int'(o_toggle),   0);
    chk("rst_pending",  int'(o_pending),  0);
    chk("rst_busy",     int'(o_busy),     0);
    chk("rst_drop",     int'(o_drop),     0);
    chk("rst_overflow", int'(o_overflow), 0);
    #1 i_rst = 1'b0;
    repeat (3) @(negedge clk);

`ifdef STROBE_TO_TOGGLE_TX_ACK_EN
    // Three strobes: flips wait for the echoed ack each time (5-cycle round trip).
    t0 = cyc + 1;
    exp_q.push_back(t0); exp_q.push_back(t0 + 5); exp_q.push_back(t0 + 10);
    i_strobe = 1'b1;
    repeat (3) @(negedge clk);
    i_strobe = 1'b0;
    chk("ack_pending_peak", int'(o_pending), 2);
    repeat (12) @(negedge clk);
    chk("ack_busy_before_match", int'(o_busy), 1);
    @(negedge clk);
    chk("ack_busy_after_match", int'(o_busy), 0);
    chk("ack_pending_drained",  int'(o_pending), 0);

    // Frozen ack: one flip, then stuck in WAIT with three queued events.
    #1 hold_ack = 1'b1;
    t0 = cyc + 1;
    exp_q.push_back(t0);
    i_strobe = 1'b1;
    repeat (4) @(negedge clk);
    i_strobe = 1'b0;
    repeat (20) @(negedge clk);
    chk("hold_busy",    int'(o_busy),    1);
    chk("hold_pending", int'(o_pending), 3);
    #1 i_rst = 1'b1;
    #1;
`else
    // Single strobe: immediate flip, busy for MIN_GAP cycles.
    t0 = cyc + 1;
    exp_q.push_back(t0);
    i_strobe = 1'b1;
    @(negedge clk);
    i_strobe = 1'b0;
    chk("single_toggle",  int'(o_toggle),  1);
    chk("single_pending", int'(o_pending), 0);
    chk("single_busy",    int'(o_busy),    1);
    repeat (3) begin
      @(negedge clk);
      chk("single_busy_hold", int'(o_busy), 1);
    end
    @(negedge clk);
    chk("single_busy_end", int'(o_busy), 0);

    // Burst of 5: flips every 4 cycles, pending peaks at 3.
    wait_idle();
    t0 = cyc + 1;
    for (int k = 0; k < 5; k++) exp_q.push_back(t0 + 4 * k);
    for (int k = 0; k < 5; k++) begin
      i_strobe = 1'b1;
      @(negedge clk);
      chk("burst_pending", int'(o_pending), (k < 3) ? k : 3);
    end
    i_strobe = 1'b0;
    repeat (11) @(negedge clk);
    chk("burst_pending_tail", int'(o_pending), 1);
    @(negedge clk);
    chk("burst_pending_zero", int'(o_pending), 0);
    chk("burst_busy_tail",    int'(o_busy),    1);
    chk("burst_no_drop",      int'(o_overflow), 0);

    // Simultaneous enqueue and dequeue keep the count unchanged.
    wait_idle();
    t0 = cyc + 1;
    exp_q.push_back(t0); exp_q.push_back(t0 + 4); exp_q.push_back(t0 + 8);
    i_strobe = 1'b1;
    repeat (2) @(negedge clk);
    i_strobe = 1'b0;
    repeat (2) @(negedge clk);
    chk("simul_pending_before", int'(o_pending), 1);
    i_strobe = 1'b1;
    @(negedge clk);
    i_strobe = 1'b0;
    chk("simul_pending_same", int'(o_pending), 1);
    repeat (4) @(negedge clk);
    chk("simul_pending_zero", int'(o_pending), 0);

    // Saturation: primer flip, then 6 back-to-back strobes; last two drop.
    wait_idle();
    t0 = cyc + 1;
    for (int k = 0; k < 5; k++) exp_q.push_back(t0 + 4 * k);
    i_strobe = 1'b1;
    @(negedge clk);
    chk("sat_drop_primer", int'(o_drop), 0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("sat_pending",  int'(o_pending),  (k < 3) ? k : 3);
      chk("sat_drop",     int'(o_drop),     (k >= 5) ? 1 : 0);
      chk("sat_overflow", int'(o_overflow), (k >= 5) ? 1 : 0);
    end
    i_strobe = 1'b0;
    @(negedge clk);
    chk("sat_drop_clear", int'(o_drop), 0);
    wait_idle();
    chk("sat_overflow_sticky", int'(o_overflow), 1);
    chk("sat_pending_drained", int'(o_pending),  0);

    // Reset mid-WAIT with three queued events.
    t0 = cyc + 1;
    exp_q.push_back(t0);
    i_strobe = 1'b1;
    repeat (4) @(negedge clk);
    i_strobe = 1'b0;
    chk("prerst_pending", int'(o_pending), 3);
    chk("prerst_toggle",  int'(o_toggle),  1);
    chk("prerst_busy",    int'(o_busy),    1);
    #1 i_rst = 1'b1;
    #1;
`endif
    chk("midrst_toggle",   int'(o_toggle),   0);
    chk("midrst_pending",  int'(o_pending),  0);
    chk("midrst_busy",     int'(o_busy),     0);
    chk("midrst_drop",     int'(o_drop),     0);
    chk("midrst_overflow", int'(o_overflow), 0);
    repeat (2) @(negedge clk);
    #1 begin
      i_rst    = 1'b0;
      hold_ack = 1'b0;
    end

    // Recovery after reset: idle, queue discarded, fresh strobe bypasses.
    repeat (6) @(negedge clk);
    chk("postrst_busy",    int'(o_busy),    0);
    chk("postrst_toggle",  int'(o_toggle),  0);
    chk("postrst_pending", int'(o_pending), 0);
    t0 = cyc + 1;
    exp_q.push_back(t0);
    i_strobe = 1'b1;
    @(negedge clk);
    i_strobe = 1'b0;
    chk("postrst_flip_toggle",  int'(o_toggle),  1);
    chk("postrst_flip_pending", int'(o_pending), 0);
    wait_idle();
    repeat (4) @(negedge clk);
    chk("exp_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
